// File: rtl/sram_rd_sched.sv
// Round-robin read scheduler for one shared single-port SRAM read channel.
// Picks at most one enabled requester per cycle, issues its address to the
// SRAM, and returns the read data RD_LAT cycles later tagged with its port.
module sram_rd_sched #(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic [NUM_PORTS-1:0]           rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0]    rd_addr,
  output logic [NUM_PORTS-1:0]           rd_gnt,
  input  logic                           sram_wr_busy,
  output logic                           sram_rd_en,
  output logic [ADDR_W-1:0]              sram_rd_addr,
  input  logic [DATA_W-1:0]              sram_rd_data,
  output logic                           rsp_valid,
  output logic [$clog2(NUM_PORTS)-1:0]   rsp_port,
  output logic [DATA_W-1:0]              rsp_data
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  // Last granted port; the search for the next winner starts just after it.
  logic [PORT_W-1:0]    ptr;
  logic [PORT_W-1:0]    winner;
  logic [PORT_W-1:0]    idx;
  logic                 found;
  logic                 issue;
  logic [NUM_PORTS-1:0] elig;

  // Tag pipe that mirrors the SRAM read latency.
  logic                 pipe_v [RD_LAT];
  logic [PORT_W-1:0]    pipe_p [RD_LAT];

  // The port granted this cycle still shows its request, so mask it out.
  assign elig  = rd_req & port_en & ~rd_gnt;
  assign issue = found && !sram_wr_busy;

  // Round-robin search: first eligible port after ptr, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      // Truncation to PORT_W bits gives the modulo-NUM_PORTS wrap.
      idx = ptr + PORT_W'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant, SRAM command and pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      rd_gnt       <= '0;
      sram_rd_en   <= 1'b0;
      sram_rd_addr <= '0;
      ptr          <= PORT_W'(NUM_PORTS - 1);
    end else if (issue) begin
      rd_gnt       <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner;
      sram_rd_en   <= 1'b1;
      sram_rd_addr <= rd_addr[int'(winner)*ADDR_W +: ADDR_W];
      ptr          <= winner;
    end else begin
      rd_gnt     <= '0;
      sram_rd_en <= 1'b0;
    end
  end

  // Response tag pipe: {valid, port} follows the SRAM read through its latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this pipe is cleared on reset so reads in flight never produce a response.
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_p[i] <= '0;
      end
    end else begin
      pipe_v[0] <= sram_rd_en;
      pipe_p[0] <= sram_rd_en ? ptr : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[RD_LAT-1];
  assign rsp_port  = pipe_p[RD_LAT-1];
  assign rsp_data  = sram_rd_data;

endmodule

// File: tb/tb_sram_rd_sched.sv
// Self-checking bench for sram_rd_sched: two instances (RD_LAT=1 and 3)
// share the same stimulus; a cycle-level reference model predicts grants,
// SRAM commands and responses, and directed literals pin the model.
module tb_sram_rd_sched;

  localparam int NP = 16;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int HN = 4096;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    port_en = '1;
  logic [NP-1:0]    rd_req = '0;
  logic             sram_wr_busy = 1'b0;
  logic [NP*AW-1:0] rd_addr = '0;

  logic [NP-1:0] gnt1, gnt3;
  logic          en1, en3;
  logic [AW-1:0] addr1, addr3;
  logic [DW-1:0] sd1, sd3;
  logic          rv1, rv3;
  logic [3:0]    rp1, rp3;
  logic [DW-1:0] rd1, rd3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_rd_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(gnt1), .sram_wr_busy(sram_wr_busy), .sram_rd_en(en1), .sram_rd_addr(addr1),
    .sram_rd_data(sd1), .rsp_valid(rv1), .rsp_port(rp1), .rsp_data(rd1));

  sram_rd_sched #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .port_en(port_en), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(gnt3), .sram_wr_busy(sram_wr_busy), .sram_rd_en(en3), .sram_rd_addr(addr3),
    .sram_rd_data(sd3), .rsp_valid(rv3), .rsp_port(rp3), .rsp_data(rd3));

  // SRAM contents: each word is a fixed scramble of its address.
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {2'b10, a} ^ 16'h3C5A;
  endfunction

  // SRAM behaviour: data for the address issued RD_LAT cycles ago.
  logic [AW-1:0] sh1;
  logic [AW-1:0] sh3 [3];
  always @(posedge clk) begin
    sh1    <= addr1;
    sh3[0] <= addr3;
    sh3[1] <= sh3[0];
    sh3[2] <= sh3[1];
  end
  assign sd1 = mem(sh1);
  assign sd3 = mem(sh3[2]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Round-robin pick: first eligible port after p, wrapping; -1 if none.
  function automatic int pick(input logic [NP-1:0] elig, input int p, input logic busy);
    if (busy || elig == '0) return -1;
    for (int k = 1; k <= NP; k++) begin
      if (elig[(p + k) % NP]) return (p + k) % NP;
    end
    return -1;
  endfunction

  int            cyc = 0;
  logic [NP-1:0] m_gnt = '0;
  logic          m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            m_ptr = NP - 1;
  int            m_win;
  logic          hist_v   [HN];
  int            hist_p   [HN];
  logic [AW-1:0] hist_a   [HN];
  logic          rst_seen [HN];

  always_comb m_win = pick(rd_req & port_en & ~m_gnt, m_ptr, sram_wr_busy);

  // Model state advances on each clock edge; index cyc+1 is the cycle that follows.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_gnt             <= '0;
      m_en              <= 1'b0;
      m_addr            <= '0;
      m_ptr             <= NP - 1;
      hist_v[cyc+1]     <= 1'b0;
      rst_seen[cyc+1]   <= 1'b1;
    end else begin
      rst_seen[cyc+1] <= 1'b0;
      if (m_win >= 0) begin
        m_gnt         <= NP'(1) << m_win;
        m_en          <= 1'b1;
        m_addr        <= rd_addr[m_win*AW +: AW];
        m_ptr         <= m_win;
        hist_v[cyc+1] <= 1'b1;
        hist_p[cyc+1] <= m_win;
        hist_a[cyc+1] <= rd_addr[m_win*AW +: AW];
      end else begin
        m_gnt         <= '0;
        m_en          <= 1'b0;
        hist_v[cyc+1] <= 1'b0;
      end
    end
  end

  // A read issued at cycle t-lat answers at t unless a reset landed in between.
  function automatic logic exp_valid(input int t, input int lat);
    if (t - lat < 1) return 1'b0;
    if (!hist_v[t-lat]) return 1'b0;
    for (int c = t - lat + 1; c <= t; c++) begin
      if (rst_seen[c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("gnt1", gnt1, m_gnt);
      check("gnt3", gnt3, m_gnt);
      check("rd_en1", en1, m_en);
      check("rd_en3", en3, m_en);
      check("rd_addr1", addr1, m_addr);
      check("rd_addr3", addr3, m_addr);
      check("rsp_valid1", rv1, exp_valid(cyc, 1));
      check("rsp_valid3", rv3, exp_valid(cyc, 3));
      if (exp_valid(cyc, 1)) begin
        check("rsp_port1", rp1, hist_p[cyc-1]);
        check("rsp_data1", rd1, mem(hist_a[cyc-1]));
      end
      if (exp_valid(cyc, 3)) begin
        check("rsp_port3", rp3, hist_p[cyc-3]);
        check("rsp_data3", rd3, mem(hist_a[cyc-3]));
      end
      if (rst_seen[cyc]) begin
        check("rst_rsp_port1", rp1, 0);
        check("rst_rsp_port3", rp3, 0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench in the first cycle after reset, with rst_n already high.
  task automatic do_reset();
    rst_n = 1'b0;
    rd_req = '0;
    sram_wr_busy = 1'b0;
    port_en = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addrs(input bit by_index);
    for (int i = 0; i < NP; i++)
      rd_addr[i*AW +: AW] = by_index ? AW'(i) : AW'(14'h1000 + i * 14'h111);
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    int c = 0;
    int idx = 99;
    for (int i = 0; i < NP; i++) if (v[i]) begin c++; idx = i; end
    return (c == 1) ? idx : 99;
  endfunction

  logic [NP-1:0] pats [8] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h1248,
                              16'hA5A5, 16'h0F00, 16'h0030, 16'h7FFE};

  initial begin
    // Test 1: everyone requests, addresses equal port index.
    set_addrs(1'b1);
    do_reset();
    sample();
    check("reset_gnt", gnt1, 0);
    check("reset_en", en1, 0);
    check("reset_addr", addr1, 0);
    check("reset_rsp_valid", rv1, 0);
    rd_req = '1;
    for (int i = 0; i <= NP; i++) begin
      tick();
      sample();
      check("t1_order", onehot_idx(gnt1), i % NP);
      check("t1_addr", addr1, i % NP);
    end

    // Test 2: lone requester 5 is granted every other cycle.
    set_addrs(1'b0);
    do_reset();
    rd_req = NP'(1) << 5;
    for (int i = 0; i < 10; i++) begin
      tick();
      sample();
      check("t2_gnt5", gnt1[5], (i % 2) == 0);
      check("t2_rsp_valid", rv1, (i % 2) == 1);
      if (i % 2 == 1) begin
        check("t2_rsp_port", rp1, 5);
        check("t2_rsp_data", rd1, 16'hA90F);
      end
    end

    // Test 3: after granting port 3, port 9 wins over port 1.
    do_reset();
    rd_req = NP'(1) << 3;
    tick();
    rd_req = (NP'(1) << 1) | (NP'(1) << 9);
    sample();
    check("t3_gnt3", onehot_idx(gnt1), 3);
    tick();
    sample();
    check("t3_gnt9", onehot_idx(gnt1), 9);
    tick();
    rd_req = '0;
    sample();
    check("t3_gnt1", onehot_idx(gnt1), 1);

    // Test 4: write path owns the SRAM for 4 cycles.
    do_reset();
    sram_wr_busy = 1'b1;
    rd_req = (NP'(1) << 2) | (NP'(1) << 7);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) sram_wr_busy = 1'b0;
      sample();
      check("t4_busy_gnt", gnt1, 0);
      check("t4_busy_en", en1, 0);
    end
    tick();
    sample();
    check("t4_first", onehot_idx(gnt1), 2);
    tick();
    rd_req = '0;
    sample();
    check("t4_second", onehot_idx(gnt1), 7);

    // Test 5: port 0 disabled, everyone else requests.
    do_reset();
    port_en = 16'hFFFE;
    rd_req = '1;
    for (int i = 0; i < NP; i++) begin
      tick();
      sample();
      check("t5_order", onehot_idx(gnt1), 1 + (i % 15));
    end

    // Test 6: RD_LAT=3, grants to 4,6,8 at cycles 1,3,5, reset at cycle 6.
    do_reset();
    rd_req = NP'(1) << 4;                       // cycle 0
    tick(); rd_req = '0;           sample();    // cycle 1
    check("t6_gnt4", onehot_idx(gnt3), 4);
    tick(); rd_req = NP'(1) << 6;  sample();    // cycle 2
    tick(); rd_req = '0;           sample();    // cycle 3
    check("t6_gnt6", onehot_idx(gnt3), 6);
    tick(); rd_req = NP'(1) << 8;  sample();    // cycle 4
    check("t6_rsp4_valid", rv3, 1);
    check("t6_rsp4_port", rp3, 4);
    tick(); rd_req = '0;           sample();    // cycle 5
    check("t6_gnt8", onehot_idx(gnt3), 8);
    tick(); rst_n = 1'b0;          sample();    // cycle 6
    check("t6_rsp6_valid", rv3, 1);
    check("t6_rsp6_port", rp3, 6);
    tick(); rst_n = 1'b1;          sample();    // cycle 7
    check("t6_zero_gnt", gnt3, 0);
    check("t6_zero_en", en3, 0);
    check("t6_zero_addr", addr3, 0);
    check("t6_zero_rsp", {rv3, rp3}, 0);
    tick();                        sample();    // cycle 8
    check("t6_no_rsp8", rv3, 0);

    // Mixed traffic: changing requests, enables and busy; model-checked only.
    for (int i = 0; i < 48; i++) begin
      tick();
      rd_req = pats[i % 8];
      port_en = (i % 11 == 3) ? 16'h00FF : 16'hFFFF;
      sram_wr_busy = (i % 5 == 4);
    end
    rd_req = '0;
    sram_wr_busy = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
